// File: rtl/mac_arbiter_pkg.sv
// par_parameter: operand width parameter and FSM state type shared by the MAC arbiter files
package par_parameter;
    localparam int par = 7;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/mac_arbiter_mac_stage.sv
// mac_stage: registered unsigned a*b+c at full 2*(msb+1) width, updated only when enabled
module mac_stage
    import par_parameter::*;
#(
    parameter int p_msb = par
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic [p_msb:0]       i_a,
    input  logic [p_msb:0]       i_b,
    input  logic [p_msb:0]       i_c,
    output logic [2*p_msb+1:0]   o_q
);
    localparam int w = 2*p_msb+2;
    always_ff @(posedge clk) begin
        if (!rst_n) o_q <= '0;
        else if (i_en) o_q <= w'(i_a) * w'(i_b) + w'(i_c);
    end
endmodule

// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin arbiter between two requesters sharing one multiply-accumulate unit
module mac_arbiter
    import par_parameter::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic [par:0]       a0,
    input  logic [par:0]       b0,
    input  logic [par:0]       c0,
    input  logic [par:0]       a1,
    input  logic [par:0]       b1,
    input  logic [par:0]       c1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               res_valid,
    output logic               res_id,
    output logic [2*par+1:0]   res_data,
    input  logic               res_ready,
    output logic [7:0]         op_cnt
);
    state_t       r_state;
    logic [par:0] r_a, r_b, r_c;
    logic         r_id, r_last_id;
    logic         w_idle, w_pick1;
    assign w_idle  = rst_n && (r_state == IDLE);
    // on a tie, the requester that was not served last wins
    assign w_pick1 = req1 && (!req0 || !r_last_id);
    assign gnt1    = w_idle && w_pick1;
    assign gnt0    = w_idle && req0 && !w_pick1;
    mac_stage #(.p_msb(par)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (r_state == CALC),
        .i_a   (r_a),
        .i_b   (r_b),
        .i_c   (r_c),
        .o_q   (res_data)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            op_cnt    <= '0;
            r_last_id <= 1'b1;
            r_id      <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
        end else begin
            case (r_state)
                IDLE: if (gnt0 || gnt1) begin
                    r_a       <= gnt1 ? a1 : a0;
                    r_b       <= gnt1 ? b1 : b0;
                    r_c       <= gnt1 ? c1 : c0;
                    r_id      <= gnt1;
                    r_last_id <= gnt1;
                    r_state   <= CALC;
                end
                CALC: begin
                    res_id    <= r_id;
                    res_valid <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    op_cnt    <= op_cnt + 8'd1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_mac_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, req0, req1, res_ready;
    logic [7:0]  a0, b0, c0, a1, b1, c1;
    logic        gnt0, gnt1, res_valid, res_id;
    logic [15:0] res_data;
    logic [7:0]  op_cnt;
    logic [16:0] sb_q[$];
    logic [16:0] m_exp;
    int          n_cmp = 0;
    int          n_err = 0;

    mac_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .c0(c0), .a1(a1), .b1(b1), .c1(c1),
        .gnt0(gnt0), .gnt1(gnt1), .res_valid(res_valid), .res_id(res_id),
        .res_data(res_data), .res_ready(res_ready), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // a transfer happens on the next posedge whenever valid and ready are seen here
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: unexpected result id=%0d data=%0d, expected none", res_id, res_data);
            end else begin
                m_exp = sb_q.pop_front();
                chk("res_id", 32'(res_id), 32'(m_exp[16]));
                chk("res_data", 32'(res_data), 32'(m_exp[15:0]));
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input bit id);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = id ? gnt1 : gnt0;
        end
        if (!seen) chk(id ? "gnt1_timeout" : "gnt0_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_low();
        bit low = 1'b0;
        for (int k = 0; k < 20 && !low; k++) begin
            @(negedge clk);
            low = !res_valid;
        end
        if (!low) chk("transfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic op(input bit id, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [15:0] exp);
        @(posedge clk);
        #1;
        sb_q.push_back({id, exp});
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; c1 = c; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; c0 = c; end
        wait_gnt(id);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        chk("calc_valid_low", 32'(res_valid), 32'd0);
        chk("calc_gnt_low", 32'({gnt0, gnt1}), 32'd0);
        @(posedge clk);
        #1 chk("done_valid_high", 32'(res_valid), 32'd1);
        wait_low();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; res_ready = 1'b1;
        a0 = '0; b0 = '0; c0 = '0; a1 = '0; b1 = '0; c1 = '0;
        // reset state, with requests held to confirm grants are suppressed
        repeat (2) @(posedge clk);
        #1 req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_op_cnt", 32'(op_cnt), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        @(posedge clk);
        #1 req0 = 1'b0; req1 = 1'b0;
        do_reset();

        op(1'b0, 8'd3, 8'd4, 8'd5, 16'd17);
        chk("op_cnt_single", 32'(op_cnt), 32'd1);
        op(1'b1, 8'd255, 8'd255, 8'd255, 16'hFF00);
        chk("op_cnt_max", 32'(op_cnt), 32'd2);

        // simultaneous requests right after reset: 0 first, then 1
        do_reset();
        sb_q.push_back({1'b0, 16'd21});
        sb_q.push_back({1'b1, 16'd49});
        req0 = 1'b1; a0 = 8'd2; b0 = 8'd10; c0 = 8'd1;
        req1 = 1'b1; a1 = 8'd7; b1 = 8'd7;  c1 = 8'd0;
        wait_gnt(1'b0);
        chk("tie_gnt1_low", 32'(gnt1), 32'd0);
        @(posedge clk);
        #1 req0 = 1'b0;
        wait_gnt(1'b1);
        chk("second_gnt0_low", 32'(gnt0), 32'd0);
        @(posedge clk);
        #1 req1 = 1'b0;
        @(posedge clk);
        #1 wait_low();
        chk("op_cnt_tie", 32'(op_cnt), 32'd2);

        // back-pressure with a waiting requester
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        sb_q.push_back({1'b0, 16'd110});
        req0 = 1'b1; a0 = 8'd10; b0 = 8'd10; c0 = 8'd10;
        wait_gnt(1'b0);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b1; a1 = 8'd1; b1 = 8'd1; c1 = 8'd1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_data", 32'(res_data), 32'd110);
            chk("bp_gnt1", 32'(gnt1), 32'd0);
        end
        chk("bp_op_cnt", 32'(op_cnt), 32'd2);
        sb_q.push_back({1'b1, 16'd2});
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_gnt(1'b1);
        chk("bp_single_transfer", 32'(op_cnt), 32'd3);
        @(posedge clk);
        #1 req1 = 1'b0;
        @(posedge clk);
        #1 wait_low();
        chk("op_cnt_bp", 32'(op_cnt), 32'd4);

        // reset while in CALC discards the operation
        do_reset();
        req0 = 1'b1; a0 = 8'd9; b0 = 8'd9; c0 = 8'd9;
        wait_gnt(1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("calc_rst_gnt0", 32'(gnt0), 32'd0);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        rst_n = 1'b1;
        chk("calc_rst_valid", 32'(res_valid), 32'd0);
        chk("calc_rst_op_cnt", 32'(op_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 chk("calc_rst_no_result", 32'(res_valid), 32'd0);

        // 256 transfers wrap the counter
        for (int i = 0; i < 256; i++) begin
            op(1'b0, 8'(i), 8'd2, 8'd1, 16'(2 * i + 1));
            if (i == 254) chk("op_cnt_255", 32'(op_cnt), 32'd255);
        end
        chk("op_cnt_wrap", 32'(op_cnt), 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
